// File: rtl/seg7_pkg.sv
// Shared types, constants and helpers for the four-digit seven-segment scanner.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents:
//   HEX_SEG   - hex nibble to active-low segment pattern, seg[0]=a .. seg[6]=g
//   SEG_OFF   - all segments dark
//   AN_OFF    - all anodes off
//   pins_t    - the registered pin bundle driven by the scanner
//   lz_blank  - leading-zero test for one digit position of the display word
package seg7_pkg;

    typedef logic [1:0]  digit_t;
    typedef logic [3:0]  nib_t;
    typedef logic [15:0] word_t;

    localparam logic [6:0] SEG_OFF = 7'h7F;
    localparam logic [3:0] AN_OFF  = 4'hF;

    // Index 0 sits in the least significant slice, so the list runs F down to 0.
    localparam logic [15:0][6:0] HEX_SEG = {
        7'b0001110,   // F
        7'b0000110,   // E
        7'b0100001,   // d
        7'b1000110,   // C
        7'b0000011,   // b
        7'b0001000,   // A
        7'b0010000,   // 9
        7'b0000000,   // 8
        7'b1111000,   // 7
        7'b0000010,   // 6
        7'b0010010,   // 5
        7'b0011001,   // 4
        7'b0110000,   // 3
        7'b0100100,   // 2
        7'b1111001,   // 1
        7'b1000000    // 0
    };

    // Everything that leaves the block goes through one register of this type,
    // so seg, dp, an and frame always change on the same edge.
    typedef struct packed {
        logic [6:0] seg;
        logic       dp;
        logic [3:0] an;
        logic       frame;
    } pins_t;

    localparam pins_t PINS_RESET = '{seg: SEG_OFF, dp: 1'b1, an: AN_OFF, frame: 1'b0};

    // A digit is a leading zero when it and every more significant digit are
    // zero. The rightmost digit always shows, so a zero word reads "   0".
    function automatic logic lz_blank(input word_t disp, input digit_t digit);
        word_t upper;
        upper = disp >> {digit, 2'b00};
        return (digit != 2'd0) && (upper == 16'h0000);
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Hex nibble to seven-segment pattern, active-low (a segment is lit when its bit is 0).
// Latency: combinational, zero cycles.
// Backpressure: none; output follows the input continuously.
//
// Ports:
//   nib  - hex digit 0..F
//   seg  - segment pattern, seg[0]=a .. seg[6]=g
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg
);

    assign seg = HEX_SEG[nib];

endmodule

// File: rtl/seg7_scan.sv
// Four-digit multiplexed seven-segment driver: hex decode, anode scan, PWM brightness, leading-zero blanking.
// Latency: one cycle from scan counter state to pins; a loaded word shows from the next frame's digit 0.
// Backpressure: none; load is a fire-and-forget strobe and the latest load in a frame wins.
//
// Ports:
//   clock, n_reset - rising-edge clock, asynchronous active-low reset
//   value, load    - word to display ([3:0] = rightmost digit) and its capture strobe
//   dp_mask        - per-digit decimal point enable, active-high, live
//   blank_lz       - blank leading zeros, live
//   bright         - brightness 0..15, live
//   seg, dp, an    - active-low segment, decimal point and anode pins
//   frame          - one-cycle pulse on the last cycle of digit 3's slot
module seg7_scan
    import seg7_pkg::*;
#(
    parameter int DIGIT_CYCLES = 100000,
    parameter int BLANK        = 16
)(
    input  logic        n_reset,
    input  logic        clock,
    input  logic [15:0] value,
    input  logic        load,
    input  logic [3:0]  dp_mask,
    input  logic        blank_lz,
    input  logic [3:0]  bright,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [3:0]  an,
    output logic        frame
);

    // Slot counter width, and a wider width for the brightness product:
    // (bright+1) is at most 16, so four extra bits hold the product and the
    // fifth keeps BLANK + on-length from wrapping.
    localparam int CW = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
    localparam int PW = CW + 5;

    localparam logic [CW-1:0] SLOT_LAST = CW'(DIGIT_CYCLES - 1);
    localparam logic [PW-1:0] BLANK_W   = PW'(BLANK);
    localparam logic [PW-1:0] ACTIVE_W  = PW'(DIGIT_CYCLES - BLANK);

    // ------------------------------------------------------------------
    // Scan counters
    // ------------------------------------------------------------------
    logic [CW-1:0] slot_cnt;
    digit_t        digit;
    logic          slot_wrap;
    logic          frame_hit;

    assign slot_wrap = (slot_cnt == SLOT_LAST);
    assign frame_hit = slot_wrap && (digit == 2'd3);

    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            slot_cnt <= '0;
            digit    <= 2'd0;
        end else if (slot_wrap) begin
            slot_cnt <= '0;
            digit    <= digit + 2'd1;
        end else begin
            slot_cnt <= slot_cnt + CW'(1);
        end
    end

    // ------------------------------------------------------------------
    // Pending / displayed words
    // ------------------------------------------------------------------
    // disp only changes on the edge that ends the cycle in which the frame
    // pin is high, i.e. while the counters sit at digit 0, slot 0. Nothing is
    // lit in slot 0 (BLANK >= 1), so a half-old, half-new word is never seen.
    // A load landing on that same edge bypasses pending so it is not lost.
    word_t pending;
    word_t disp;
    word_t transfer_word;
    pins_t pins_q;

    assign transfer_word = load ? value : pending;

    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            pending <= '0;
            disp    <= '0;
        end else begin
            if (load) begin
                pending <= value;
            end
            if (pins_q.frame) begin
                disp <= transfer_word;
            end
        end
    end

    // ------------------------------------------------------------------
    // Digit select and decode
    // ------------------------------------------------------------------
    nib_t       nib;
    logic [6:0] dec_seg;
    logic       lz;

    assign nib = disp[{digit, 2'b00} +: 4];
    assign lz  = blank_lz && lz_blank(disp, digit);

    seg7_decode u_decode (
        .nib (nib),
        .seg (dec_seg)
    );

    // ------------------------------------------------------------------
    // Brightness window
    // ------------------------------------------------------------------
    // Anodes are lit for slot_cnt in [BLANK, BLANK + on_len). on_len scales
    // the post-blank part of the slot by (bright+1)/16, so bright=15 fills it.
    logic [PW-1:0] on_len;
    logic [PW-1:0] win_end;
    logic [PW-1:0] slot_w;
    logic          in_win;

    assign on_len  = ((PW'(bright) + PW'(1)) * ACTIVE_W) >> 4;
    assign win_end = BLANK_W + on_len;
    assign slot_w  = PW'(slot_cnt);
    assign in_win  = (slot_w >= BLANK_W) && (slot_w < win_end);

    // ------------------------------------------------------------------
    // Output register
    // ------------------------------------------------------------------
    // seg tracks the selected digit continuously; it only changes when the
    // digit or disp changes, both of which happen in slot 0 with anodes off.
    pins_t pins_nxt;

    always_comb begin
        pins_nxt       = PINS_RESET;
        pins_nxt.seg   = lz ? SEG_OFF : dec_seg;
        pins_nxt.frame = frame_hit;
        if (in_win) begin
            pins_nxt.an = ~(4'b0001 << digit);
            pins_nxt.dp = ~dp_mask[digit];
        end
    end

    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            pins_q <= PINS_RESET;
        end else begin
            pins_q <= pins_nxt;
        end
    end

    assign seg   = pins_q.seg;
    assign dp    = pins_q.dp;
    assign an    = pins_q.an;
    assign frame = pins_q.frame;

endmodule

// File: tb/tb_seg7_scan.sv
// Randomised scoreboard bench for seg7_scan with a time-indexed reference model.
// Latency: model expectation for each edge is compared at the following falling edge.
// Backpressure: n/a.
module tb_seg7_scan;

    localparam int DC    = 32;
    localparam int BL    = 2;
    localparam int FRAME = 4 * DC;

    logic        clock    = 1'b0;
    logic        n_reset  = 1'b0;
    logic [15:0] value    = 16'h0000;
    logic        load     = 1'b0;
    logic [3:0]  dp_mask  = 4'h0;
    logic        blank_lz = 1'b0;
    logic [3:0]  bright   = 4'd15;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic        frame;

    seg7_scan #(.DIGIT_CYCLES(DC), .BLANK(BL)) dut (
        .n_reset  (n_reset),
        .clock    (clock),
        .value    (value),
        .load     (load),
        .dp_mask  (dp_mask),
        .blank_lz (blank_lz),
        .bright   (bright),
        .seg      (seg),
        .dp       (dp),
        .an       (an),
        .frame    (frame)
    );

    always #5 clock = ~clock;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_chk++;
        if (act === want) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, want, $time);
    endtask

    // ------------------------------------------------------------------
    // Reference model: the display is a pure function of the number of
    // cycles since reset release, the displayed word and the live inputs.
    // ------------------------------------------------------------------
    typedef struct packed {
        logic [6:0] seg;
        logic       dp;
        logic [3:0] an;
        logic       frame;
    } exp_t;

    logic [6:0] hex_tab [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    exp_t        exp_q[$];
    int          m_t     = 0;
    logic [15:0] m_pend  = 16'h0000;
    logic [15:0] m_disp  = 16'h0000;
    logic        m_frame = 1'b0;

    always @(posedge clock) begin : model
        int          d;
        int          s;
        int          len;
        bit          on;
        logic [15:0] upper;
        exp_t        e;
        if (!n_reset) begin
            m_t     = 0;
            m_pend  = 16'h0000;
            m_disp  = 16'h0000;
            m_frame = 1'b0;
            exp_q.delete();
        end else begin
            d       = (m_t / DC) % 4;
            s       = m_t % DC;
            upper   = m_disp >> (4 * d);
            len     = ((int'(bright) + 1) * (DC - BL)) / 16;
            on      = (s >= BL) && (s < BL + len);
            e.seg   = (blank_lz && d != 0 && upper == 16'h0000) ? 7'h7F : hex_tab[upper[3:0]];
            e.an    = on ? ~(4'b0001 << d) : 4'hF;
            e.dp    = on ? ~dp_mask[d] : 1'b1;
            e.frame = (d == 3) && (s == DC - 1);
            exp_q.push_back(e);
            if (m_frame) m_disp = load ? value : m_pend;
            if (load) m_pend = value;
            m_frame = e.frame;
            m_t++;
        end
    end

    // ------------------------------------------------------------------
    // Monitor: one expectation per active edge; none queued means the DUT
    // must still be holding its reset values.
    // ------------------------------------------------------------------
    int cyc     = 0;
    int last_fr = -1;

    always @(negedge clock) begin : monitor
        exp_t e;
        if (exp_q.size() == 0) e = '{seg: 7'h7F, dp: 1'b1, an: 4'hF, frame: 1'b0};
        else e = exp_q.pop_front();
        check("pins{seg,dp,an,frame}", {seg, dp, an, frame}, e);
        if (!n_reset) begin
            last_fr = -1;
        end else if (frame) begin
            if (last_fr >= 0) check("frame_period", cyc - last_fr, FRAME);
            last_fr = cyc;
        end
        cyc++;
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (all return just after a rising edge)
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clock);
        #1;
        load = 1'b0;
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic do_load(input logic [15:0] v);
        value = v;
        load  = 1'b1;
        tick();
    endtask

    // Stops on the cycle in which the frame pin is high.
    task automatic wait_frame();
        int k = 0;
        do begin
            tick();
            k++;
        end while (!m_frame && k < 2 * FRAME);
        check("frame_wait", frame, 1'b1);
    endtask

    // Stops when the scan counters sit at the given digit and slot.
    task automatic wait_slot(input int dg, input int sl);
        int  k     = 0;
        bit  found = 1'b0;
        while (!found && k < 2 * FRAME) begin
            tick();
            k++;
            found = ((m_t / DC) % 4 == dg) && (m_t % DC == sl);
        end
        check("slot_wait", found, 1'b1);
    endtask

    initial begin
        // Reset state, then scanning 0000 at full brightness.
        run(3);
        n_reset = 1'b1;
        run(2 * FRAME + 10);

        // Mid-frame load appears only from the next frame.
        wait_slot(1, 5);
        do_load(16'h1A3F);
        run(2 * FRAME);

        // Last load of a frame wins.
        wait_slot(0, 20);
        do_load(16'h1111);
        run(40);
        do_load(16'h2222);
        run(FRAME + 20);

        // A load coincident with the frame pulse is the one transferred.
        wait_slot(1, 3);
        do_load(16'h4444);
        wait_frame();
        do_load(16'hBEEF);
        run(2 * FRAME);

        // Brightness extremes.
        bright = 4'd0;
        run(FRAME + 5);
        bright = 4'd7;
        run(FRAME);
        bright = 4'd15;

        // Leading-zero blanking.
        blank_lz = 1'b1;
        do_load(16'h0050);
        run(2 * FRAME);
        do_load(16'h0000);
        run(2 * FRAME);
        dp_mask = 4'b0101;
        do_load(16'h0300);
        run(2 * FRAME);

        // Randomised traffic with live control changes.
        repeat (1500) begin
            if ($urandom_range(0, 39) == 0) begin
                value = 16'($urandom) & {{4{$urandom_range(0, 1) == 1}}, {4{$urandom_range(0, 1) == 1}},
                                         {4{$urandom_range(0, 1) == 1}}, 4'hF};
                load  = 1'b1;
            end
            if ($urandom_range(0, 149) == 0) bright   = 4'($urandom);
            if ($urandom_range(0, 149) == 0) dp_mask  = 4'($urandom);
            if ($urandom_range(0, 199) == 0) blank_lz = 1'($urandom);
            tick();
        end

        // Asynchronous reset in the middle of digit 2's lit window.
        bright   = 4'd15;
        blank_lz = 1'b0;
        dp_mask  = 4'hF;
        do_load(16'h8888);
        run(FRAME + 10);
        wait_slot(2, 10);
        @(negedge clock);
        #1;
        n_reset = 1'b0;
        #1;
        check("rst_seg", seg, 7'h7F);
        check("rst_dp", dp, 1'b1);
        check("rst_an", an, 4'hF);
        check("rst_frame", frame, 1'b0);
        run(3);
        n_reset = 1'b1;
        run(FRAME + 10);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/seg7_scan.md
# seg7_scan

Four-digit multiplexed seven-segment display driver. It consumes the 4-bit counter values produced by the LED counter stage, packed as a 16-bit word, and shows them as hex digits on a common-anode display. It time-multiplexes the anodes, applies PWM brightness control and optional leading-zero blanking, and updates only on frame boundaries so the display never shows a torn value.

## Interface
- DIGIT_CYCLES, 100000: clock cycles per digit slot (1 ms at 100 MHz; 4 ms frame).
- BLANK, 16: cycles at the start of each slot with all anodes off (anti-ghosting); must be < DIGIT_CYCLES.
- n_reset  input  1  reset, asynchronous, active-low
- clock  input  1  clock, rising edge
- value  input  16  four hex digits; [3:0] = digit 0 (rightmost)
- load  input  1  one-cycle strobe; captures value into the pending register
- dp_mask  input  4  decimal point enable per digit, active-high, sampled live
- blank_lz  input  1  1 = blank leading zeros, sampled live
- bright  input  4  brightness 0..15, sampled live
- seg  output  7  segments, active-low; seg[0]=a … seg[6]=g
- dp  output  1  decimal point, active-low
- an  output  4  anodes, active-low; an[i] drives digit i
- frame  output  1  one-cycle pulse on the last cycle of digit 3's slot

## Operation
- Counters:
  - slot_cnt runs 0..DIGIT_CYCLES-1 and wraps.
  - On wrap, digit increments 0→1→2→3→0.
- Registers:
  - pending[15:0] is written by load.
  - disp[15:0] copies pending on the cycle after frame.
  - Several loads within one frame: the last one wins.
  - load on the same cycle as frame: that value is the one transferred.
- Nibble: nib = disp[4*digit+3 : 4*digit].
- Decode: hex 0–F, active-low.
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
- Leading-zero blank (blank_lz=1):
  - Digit k>0 is blanked (seg=1111111, dp still per mask) when nibbles k..3 are all zero.
  - Digit 0 is never blanked.
- Anode on-window: BLANK ≤ slot_cnt < BLANK + (((bright+1)*(DIGIT_CYCLES-BLANK))>>4).
  - bright=15 gives the full window after BLANK.
  - The product is computed at width clog2(DIGIT_CYCLES)+5; no overflow is permitted.
- Inside the window an = ~(1<<digit); otherwise an=1111.
- dp = ~dp_mask[digit] inside the window, otherwise 1.

## Timing
- All outputs are registered: one cycle of latency from counter state to pins.
- seg/dp are updated together with an; seg changes only while an=1111 (BLANK ≥ 1 guarantees this).
- Reset values:
  - seg=1111111, dp=1, an=1111, frame=0.
  - slot_cnt=0, digit=0, pending=0, disp=0.
- First frame after reset shows 0000, or "   0" when blank_lz=1.
- Load-to-display latency: a value loaded during frame N appears starting at frame N+1's digit 0 slot.
- Reset asserted mid-frame forces reset values immediately (asynchronously); on release scanning restarts at digit 0, slot_cnt 0.
- frame asserts when digit=3 and slot_cnt=DIGIT_CYCLES-1, registered, so it is visible one cycle later.

## Structure
- Package seg7_pkg holds:
  - the 16-entry hex→segment constant table;
  - SEG_OFF=7'h7F and AN_OFF=4'hF;
  - function lz_blank(disp, digit).
- Sub-module seg7_decode (combinational, 4-bit in, 7-bit out, active-low) is instantiated once on the selected nibble.
- Top level holds the counters, pending/disp registers, PWM window compare, and output registers.

## Test plan
Simulate with DIGIT_CYCLES=32, BLANK=2.
1. Reset, no load, bright=15, blank_lz=0 → each digit slot has an low for 30 cycles with seg=1000000; frame pulses every 128 cycles.
2. load value=16'h1A3F mid-frame → current frame still shows 0000; the next frame shows digit0=0001110, 1=0110000, 2=0001000, 3=1111001.
3. Two loads in one frame (16'h1111, then 16'h2222), and a load coincident with frame → only the last value is displayed next frame; the coincident load is taken.
4. bright=0 → an low for exactly BLANK+((1*30)>>4)-BLANK = 1 cycle per slot; bright=7 → 15 cycles.
5. blank_lz=1, value=16'h0050 → digits 3,2 blanked, digit1=0010010, digit0=1000000; value=0 → only digit 0 lit.
6. Assert n_reset mid-slot on digit 2 → outputs go to reset values within the same cycle; after release, digit 0 is scanned first and disp=0.
